// File: rtl/anton_neopixel_encoder_pkg.sv
// Shared types and timing defaults for the neopixel encoder.
// 7 MHz clock: one sub-bit per cycle, eight sub-bits per data bit.
package anton_neopixel_encoder_pkg;

  typedef enum logic {
    ENUM_STATE_RESET    = 1'b0,
    ENUM_STATE_TRANSMIT = 1'b1
  } state_e;

  localparam int RESET_CYCLES_DEF = 350;
  localparam int T0H_CYCLES_DEF   = 2;
  localparam int T1H_CYCLES_DEF   = 5;

  // GRB word goes out MSB first; out-of-range index reads as '0'.
  function automatic logic pick_bit(
    input logic [23:0] px,
    input logic [4:0]  idx
  );
    if (idx > 5'd23) return 1'b0;
    return px[5'd23 - idx];
  endfunction

endpackage

// File: rtl/anton_neopixel_encoder_if.sv
// Encoder-side bundle: control bits, stream indices and line outputs.
// master = stream controller side, slave = encoder.
interface anton_neopixel_encoder_if;
  import anton_neopixel_encoder_pkg::*;

  logic        reg_ctrl_init;
  logic        reg_ctrl_run;
  logic        reg_ctrl_loop;
  logic        stream_output;
  logic        stream_reset;
  logic        stream_bit_of;
  logic        stream_pixel_of;
  logic [2:0]  bit_pattern_index;
  logic [4:0]  pixel_bit_index;
  logic [23:0] pixel_data;
  state_e      state;
  logic        neopixel_data;
  logic        frame_done;
  logic        run_clear;

  modport master (
    output reg_ctrl_init, reg_ctrl_run, reg_ctrl_loop,
    output stream_output, stream_reset,
    output stream_bit_of, stream_pixel_of,
    output bit_pattern_index, pixel_bit_index, pixel_data,
    input  state, neopixel_data, frame_done, run_clear
  );

  modport slave (
    input  reg_ctrl_init, reg_ctrl_run, reg_ctrl_loop,
    input  stream_output, stream_reset,
    input  stream_bit_of, stream_pixel_of,
    input  bit_pattern_index, pixel_bit_index, pixel_data,
    output state, neopixel_data, frame_done, run_clear
  );

endinterface

// File: rtl/anton_neopixel_encoder_reset_timer.sv
// Latch/reset period counter with terminal-count detect.
// Freezes when not enabled; clears on init and on terminal count.
module anton_neopixel_reset_timer #(
  parameter int RESET_CYCLES = 350,
  localparam int W = $clog2(RESET_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_init,
  input  logic i_count_en,
  output logic o_tc
);

  logic [W-1:0] r_count;

  assign o_tc = i_count_en && !i_init &&
                (r_count == W'(RESET_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_init || o_tc) begin
      r_count <= '0;
    end else if (i_count_en) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/anton_neopixel_encoder.sv
// Neopixel line encoder: pulse shaping plus TRANSMIT/RESET sequencing.
// All outputs are registered, one cycle after their condition.
module anton_neopixel_encoder
  import anton_neopixel_encoder_pkg::*;
#(
  parameter int RESET_CYCLES = RESET_CYCLES_DEF,
  parameter int T0H_CYCLES   = T0H_CYCLES_DEF,
  parameter int T1H_CYCLES   = T1H_CYCLES_DEF
) (
  input logic                     clk7mhz,
  input logic                     syncn_reset,
  anton_neopixel_encoder_if.slave io_np
);

  state_e     r_state;
  state_e     w_next;
  logic       r_data;
  logic       r_frame_done;
  logic       r_run_clear;
  logic       w_frame_done;
  logic       w_run_clear;
  logic       w_tc;
  logic       w_bit;
  logic [3:0] w_thr;
  logic       w_pulse;
  logic       w_unused_run;

  // Run gating already arrives folded into stream_output/stream_reset.
  assign w_unused_run = io_np.reg_ctrl_run;

  anton_neopixel_reset_timer #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_timer (
    .i_clk      (clk7mhz),
    .i_rst_n    (syncn_reset),
    .i_init     (io_np.reg_ctrl_init),
    .i_count_en ((r_state == ENUM_STATE_RESET) && io_np.stream_reset),
    .o_tc       (w_tc)
  );

  assign w_bit   = pick_bit(io_np.pixel_data, io_np.pixel_bit_index);
  assign w_thr   = w_bit ? 4'(T1H_CYCLES) : 4'(T0H_CYCLES);
  assign w_pulse = io_np.stream_output &&
                   ({1'b0, io_np.bit_pattern_index} < w_thr);

  always_comb begin
    w_next       = r_state;
    w_frame_done = 1'b0;
    w_run_clear  = 1'b0;
    if (io_np.reg_ctrl_init) begin
      w_next = ENUM_STATE_RESET;
    end else begin
      unique case (r_state)
        ENUM_STATE_TRANSMIT: begin
          if (io_np.stream_bit_of && io_np.stream_pixel_of)
            w_next = ENUM_STATE_RESET;
        end
        ENUM_STATE_RESET: begin
          if (w_tc) begin
            w_frame_done = 1'b1;
            if (io_np.reg_ctrl_loop) w_next = ENUM_STATE_TRANSMIT;
            else                     w_run_clear = 1'b1;
          end
        end
        default: w_next = ENUM_STATE_RESET;
      endcase
    end
  end

  always_ff @(posedge clk7mhz) begin
    if (!syncn_reset) begin
      r_state      <= ENUM_STATE_RESET;
      r_data       <= 1'b0;
      r_frame_done <= 1'b0;
      r_run_clear  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_data       <= w_pulse && !io_np.reg_ctrl_init;
      r_frame_done <= w_frame_done;
      r_run_clear  <= w_run_clear;
    end
  end

  assign io_np.state         = r_state;
  assign io_np.neopixel_data = r_data;
  assign io_np.frame_done    = r_frame_done;
  assign io_np.run_clear     = r_run_clear;

endmodule

// File: tb/tb_anton_neopixel_encoder.sv
// Directed bench for the neopixel encoder.
// Inputs change 1 ns after posedge; outputs are read at that point.
module tb_anton_neopixel_encoder;
  import anton_neopixel_encoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  anton_neopixel_encoder_if np_if ();

  anton_neopixel_encoder dut (
    .clk7mhz    (clk),
    .syncn_reset(rst_n),
    .io_np      (np_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sub(input logic [23:0] px, input int b,
                           input int s, input logic last);
    np_if.stream_output     = 1'b1;
    np_if.stream_reset      = 1'b0;
    np_if.bit_pattern_index = s[2:0];
    np_if.pixel_bit_index   = b[4:0];
    np_if.pixel_data        = px;
    np_if.stream_bit_of     = (b == 23) && (s == 7);
    np_if.stream_pixel_of   = last;
    step();
  endtask

  task automatic stop_output();
    np_if.stream_output   = 1'b0;
    np_if.stream_bit_of   = 1'b0;
    np_if.stream_pixel_of = 1'b0;
  endtask

  // Holds stream_reset high for n cycles; leave_at = first cycle in TRANSMIT.
  task automatic reset_period(input int n, output int fd_cnt,
                              output int rc_cnt, output int hi_cnt,
                              output int leave_at);
    fd_cnt = 0; rc_cnt = 0; hi_cnt = 0; leave_at = 0;
    for (int i = 1; i <= n; i++) begin
      np_if.stream_reset = (leave_at == 0);
      step();
      fd_cnt += int'(np_if.frame_done);
      rc_cnt += int'(np_if.run_clear);
      hi_cnt += int'(np_if.neopixel_data);
      if (leave_at == 0 && np_if.state == ENUM_STATE_TRANSMIT) leave_at = i;
    end
    np_if.stream_reset = 1'b0;
  endtask

  task automatic test_reset();
    np_if.reg_ctrl_init = 1'b0;
    np_if.reg_ctrl_run  = 1'b1;
    np_if.reg_ctrl_loop = 1'b1;
    np_if.stream_reset  = 1'b0;
    rst_n = 1'b0;
    drive_sub(24'hFFFFFF, 0, 0, 1'b0);
    step();
    n_tests++;
    if (np_if.state !== ENUM_STATE_RESET) begin
      n_fail++; $display("FAIL reset_state: got %b want %b", np_if.state, 1'b0);
    end
    n_tests++;
    if (np_if.neopixel_data !== 1'b0) begin
      n_fail++; $display("FAIL reset_data: got %b want 0", np_if.neopixel_data);
    end
    n_tests++;
    if (np_if.frame_done !== 1'b0 || np_if.run_clear !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: got fd=%b rc=%b want 0 0",
                         np_if.frame_done, np_if.run_clear);
    end
    stop_output();
    rst_n = 1'b1;
  endtask

  task automatic test_loop_reset();
    int fd, rc, hi, lv;
    np_if.reg_ctrl_loop = 1'b1;
    reset_period(350, fd, rc, hi, lv);
    n_tests++;
    if (lv != 350) begin
      n_fail++; $display("FAIL loop_leave_cycle: got %0d want 350", lv);
    end
    n_tests++;
    if (fd != 1 || rc != 0 || hi != 0) begin
      n_fail++; $display("FAIL loop_pulses: got fd=%0d rc=%0d hi=%0d want 1 0 0",
                         fd, rc, hi);
    end
    step();
    n_tests++;
    if (np_if.frame_done !== 1'b0 || np_if.state !== ENUM_STATE_TRANSMIT) begin
      n_fail++; $display("FAIL loop_after: got fd=%b st=%b want 0 1",
                         np_if.frame_done, np_if.state);
    end
  endtask

  task automatic test_pattern();
    logic [7:0] vec, exp;
    int bad_st;
    bad_st = 0;
    for (int b = 0; b < 24; b++) begin
      vec = '0;
      for (int s = 0; s < 8; s++) begin
        drive_sub(24'h800001, b, s, 1'b1);
        vec[s] = np_if.neopixel_data;
        if (!(b == 23 && s == 7) && np_if.state !== ENUM_STATE_TRANSMIT)
          bad_st++;
      end
      exp = (b == 0 || b == 23) ? 8'h1F : 8'h03;
      n_tests++;
      if (vec !== exp) begin
        n_fail++; $display("FAIL pattern_bit%0d: got %h want %h", b, vec, exp);
      end
    end
    stop_output();
    n_tests++;
    if (bad_st != 0) begin
      n_fail++; $display("FAIL pattern_hold_tx: got %0d early exits want 0", bad_st);
    end
    n_tests++;
    if (np_if.state !== ENUM_STATE_RESET) begin
      n_fail++; $display("FAIL pattern_end_state: got %b want 0", np_if.state);
    end
  endtask

  task automatic test_timer_freeze();
    int fd, rc, hi, lv;
    np_if.reg_ctrl_loop = 1'b1;
    reset_period(100, fd, rc, hi, lv);
    for (int i = 0; i < 20; i++) step();
    reset_period(249, fd, rc, hi, lv);
    n_tests++;
    if (lv != 0 || fd != 0 || np_if.state !== ENUM_STATE_RESET) begin
      n_fail++; $display("FAIL freeze_early: got lv=%0d fd=%0d want 0 0", lv, fd);
    end
    reset_period(1, fd, rc, hi, lv);
    n_tests++;
    if (lv != 1 || fd != 1) begin
      n_fail++; $display("FAIL freeze_term: got lv=%0d fd=%0d want 1 1", lv, fd);
    end
  endtask

  task automatic test_bit_index_oob();
    drive_sub(24'hFFFFFF, 24, 3, 1'b0);
    n_tests++;
    if (np_if.neopixel_data !== 1'b0) begin
      n_fail++; $display("FAIL oob_idx24: got %b want 0", np_if.neopixel_data);
    end
    drive_sub(24'hFFFFFF, 31, 3, 1'b0);
    n_tests++;
    if (np_if.neopixel_data !== 1'b0) begin
      n_fail++; $display("FAIL oob_idx31: got %b want 0", np_if.neopixel_data);
    end
    drive_sub(24'hFFFFFF, 23, 3, 1'b0);
    n_tests++;
    if (np_if.neopixel_data !== 1'b1) begin
      n_fail++; $display("FAIL idx23_one: got %b want 1", np_if.neopixel_data);
    end
    stop_output();
  endtask

  task automatic test_run_drop();
    logic [7:0] vec;
    int hi, bad;
    hi = 0;
    for (int b = 0; b < 5; b++)
      for (int s = 0; s < 8; s++) begin
        drive_sub(24'h040000, b, s, 1'b1);
        hi += int'(np_if.neopixel_data);
      end
    n_tests++;
    if (hi != 10) begin
      n_fail++; $display("FAIL drop_pre_highs: got %0d want 10", hi);
    end
    vec = '0;
    for (int s = 0; s < 3; s++) begin
      drive_sub(24'h040000, 5, s, 1'b1);
      vec[s] = np_if.neopixel_data;
    end
    np_if.reg_ctrl_run = 1'b0;
    np_if.stream_output = 1'b0;
    np_if.bit_pattern_index = 3'd3;
    step();
    n_tests++;
    if (np_if.neopixel_data !== 1'b0) begin
      n_fail++; $display("FAIL drop_line_low: got %b want 0", np_if.neopixel_data);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (np_if.neopixel_data !== 1'b0 || np_if.state !== ENUM_STATE_TRANSMIT)
        bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL drop_hold: got %0d bad cycles want 0", bad);
    end
    np_if.reg_ctrl_run = 1'b1;
    for (int s = 3; s < 8; s++) begin
      drive_sub(24'h040000, 5, s, 1'b1);
      vec[s] = np_if.neopixel_data;
    end
    n_tests++;
    if (vec !== 8'h1F) begin
      n_fail++; $display("FAIL drop_resume_bit5: got %h want 1f", vec);
    end
    for (int b = 6; b < 24; b++)
      for (int s = 0; s < 8; s++) drive_sub(24'h040000, b, s, 1'b1);
    stop_output();
    n_tests++;
    if (np_if.state !== ENUM_STATE_RESET) begin
      n_fail++; $display("FAIL drop_end_state: got %b want 0", np_if.state);
    end
  endtask

  task automatic test_oneshot();
    int fd, rc, hi, lv;
    np_if.reg_ctrl_loop = 1'b0;
    reset_period(349, fd, rc, hi, lv);
    n_tests++;
    if (fd != 0 || rc != 0) begin
      n_fail++; $display("FAIL oneshot_early: got fd=%0d rc=%0d want 0 0", fd, rc);
    end
    reset_period(1, fd, rc, hi, lv);
    n_tests++;
    if (fd != 1 || rc != 1 || np_if.state !== ENUM_STATE_RESET) begin
      n_fail++; $display("FAIL oneshot_term: got fd=%0d rc=%0d st=%b want 1 1 0",
                         fd, rc, np_if.state);
    end
    step();
    n_tests++;
    if (np_if.frame_done !== 1'b0 || np_if.run_clear !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_single: got fd=%b rc=%b want 0 0",
                         np_if.frame_done, np_if.run_clear);
    end
    np_if.reg_ctrl_loop = 1'b1;
    reset_period(350, fd, rc, hi, lv);
    n_tests++;
    if (lv != 350) begin
      n_fail++; $display("FAIL oneshot_timer_clr: got %0d want 350", lv);
    end
  endtask

  task automatic test_init_mid_frame();
    int fd, rc, hi, lv;
    drive_sub(24'hFFFFFF, 0, 0, 1'b0);
    drive_sub(24'hFFFFFF, 0, 1, 1'b0);
    np_if.reg_ctrl_init = 1'b1;
    drive_sub(24'hFFFFFF, 0, 2, 1'b0);
    stop_output();
    n_tests++;
    if (np_if.state !== ENUM_STATE_RESET || np_if.neopixel_data !== 1'b0 ||
        np_if.frame_done !== 1'b0) begin
      n_fail++; $display("FAIL init_tx: got st=%b d=%b fd=%b want 0 0 0",
                         np_if.state, np_if.neopixel_data, np_if.frame_done);
    end
    np_if.reg_ctrl_init = 1'b0;
    reset_period(350, fd, rc, hi, lv);
    n_tests++;
    if (lv != 350) begin
      n_fail++; $display("FAIL init_timer_zero: got %0d want 350", lv);
    end
    np_if.reg_ctrl_init = 1'b1;
    step();
    np_if.reg_ctrl_init = 1'b0;
    reset_period(349, fd, rc, hi, lv);
    np_if.reg_ctrl_init = 1'b1;
    np_if.stream_reset  = 1'b1;
    step();
    np_if.stream_reset  = 1'b0;
    np_if.reg_ctrl_init = 1'b0;
    n_tests++;
    if (np_if.state !== ENUM_STATE_RESET || np_if.frame_done !== 1'b0 ||
        np_if.run_clear !== 1'b0) begin
      n_fail++; $display("FAIL init_vs_tc: got st=%b fd=%b rc=%b want 0 0 0",
                         np_if.state, np_if.frame_done, np_if.run_clear);
    end
    reset_period(350, fd, rc, hi, lv);
    n_tests++;
    if (lv != 350 || fd != 1) begin
      n_fail++; $display("FAIL init_vs_tc_after: got lv=%0d fd=%0d want 350 1", lv, fd);
    end
  endtask

  task automatic test_sync_reset();
    int fd, rc, hi, lv;
    drive_sub(24'hFFFFFF, 0, 0, 1'b0);
    np_if.bit_pattern_index = 3'd1;
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    step();
    n_tests++;
    if (np_if.neopixel_data !== 1'b1 || np_if.state !== ENUM_STATE_TRANSMIT) begin
      n_fail++; $display("FAIL rst_glitch: got d=%b st=%b want 1 1",
                         np_if.neopixel_data, np_if.state);
    end
    rst_n = 1'b0;
    drive_sub(24'hFFFFFF, 0, 2, 1'b0);
    stop_output();
    rst_n = 1'b1;
    n_tests++;
    if (np_if.neopixel_data !== 1'b0 || np_if.state !== ENUM_STATE_RESET) begin
      n_fail++; $display("FAIL rst_mid_frame: got d=%b st=%b want 0 0",
                         np_if.neopixel_data, np_if.state);
    end
    reset_period(200, fd, rc, hi, lv);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    reset_period(350, fd, rc, hi, lv);
    n_tests++;
    if (lv != 350) begin
      n_fail++; $display("FAIL rst_timer_clr: got %0d want 350", lv);
    end
  endtask

  initial begin
    test_reset();
    test_loop_reset();
    test_pattern();
    test_timer_freeze();
    test_bit_index_oob();
    test_run_drop();
    test_oneshot();
    test_init_mid_frame();
    test_sync_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/anton_neopixel_encoder.md
# anton_neopixel_encoder

Downstream stage of the neopixel stream controller. Consumes the sub-bit, bit and pixel indices plus the current pixel's 24-bit colour word, and drives the single-wire neopixel data line with correctly shaped 0/1 pulses. Owns the TRANSMIT/RESET state that the stream controller consumes, including the latch/reset low period between frames. Handles loop and one-shot frame sequencing by requesting a clear of the run bit.

## Interface
- RESET_CYCLES, 350: low cycles of the reset/latch period (50 µs at 7 MHz).
- T0H_CYCLES, 2: high cycles for a '0' bit (≈286 ns).
- T1H_CYCLES, 5: high cycles for a '1' bit (≈714 ns); must satisfy T0H_CYCLES < T1H_CYCLES < 8.
- clk7mhz  in  1  single clock for the block.
- syncn_reset  in  1  reset, synchronous, active-low.
- reg_ctrl_init  in  1  software init; forces RESET state and clears the timer.
- reg_ctrl_run  in  1  run enable (read only here).
- reg_ctrl_loop  in  1  1 = restart transmission after reset period; 0 = one-shot.
- stream_output  in  1  controller is in an active transmit cycle.
- stream_reset  in  1  controller is in an active reset cycle.
- stream_bit_of  in  1  last sub-bit of the last bit of the current pixel.
- stream_pixel_of  in  1  current pixel is the last one in the frame.
- bit_pattern_index  in  3  sub-bit step 0–7.
- pixel_bit_index  in  5  bit 0–23 of the current pixel; 0 is transmitted first.
- pixel_data  in  24  current pixel in GRB order, stable while pixel_index is unchanged.
- state  out  1  `ENUM_STATE_TRANSMIT` or `ENUM_STATE_RESET`.
- neopixel_data  out  1  serial line to the LED chain.
- frame_done  out  1  one-cycle pulse when the reset period completes.
- run_clear  out  1  one-cycle pulse requesting that reg_ctrl_run be cleared (one-shot mode).

## Operation
- Bit select: bit_value = pixel_data[23 − pixel_bit_index]. pixel_bit_index > 23 is never produced; if it occurs, treat bit_value as 0.
- Pulse shaping: when stream_output is high, next neopixel_data = (bit_pattern_index < (bit_value ? T1H_CYCLES : T0H_CYCLES)). Otherwise next neopixel_data = 0.
- State machine, 2 states:
  - RESET → TRANSMIT: when stream_reset is high and the timer equals RESET_CYCLES−1 and reg_ctrl_loop=1.
  - RESET hold: same timer condition with reg_ctrl_loop=0. State stays RESET, frame_done and run_clear both pulse, and the timer clears to 0.
  - TRANSMIT → RESET: on stream_bit_of && stream_pixel_of. The last bit completes first.
- Reset timer: counts only while state=RESET and stream_reset is high. It freezes when stream_reset is low, e.g. run deasserted. It clears on leaving RESET and on the frame_done pulse.
- Timer width: `CLOG2(RESET_CYCLES+1)`. There is no wrap-around, because the timer clears at RESET_CYCLES−1.
- frame_done also pulses on the RESET→TRANSMIT transition (loop mode).
- reg_ctrl_init has priority over all transitions: state=RESET, timer=0, neopixel_data=0, no pulses.
- Run deasserted mid-pixel: stream_output drops, the line goes low next cycle, and state holds. Resumption continues from the frozen indices. The glitched bit is accepted.

## Timing
- Reset values (syncn_reset=0): state=RESET, timer=0, neopixel_data=0, frame_done=0, run_clear=0.
- neopixel_data is registered and has a latency of 1 cycle from bit_pattern_index.
- The state change is visible one cycle after its condition. The controller sees the new state the next cycle, so no extra transmit sub-bit is emitted.
- A full bit is 8 cycles (1.143 µs). A pixel is 192 cycles.
- Reset period: exactly RESET_CYCLES cycles with stream_reset high between the last data sub-bit and the first sub-bit of the next frame.
- frame_done and run_clear are high for exactly one cycle. They are not asserted when reg_ctrl_init is high.
- Simultaneous reg_ctrl_init and timer terminal count: init wins, and no pulse is emitted.

## Structure
- Shared header anton_common.vh holds:
  - `ENUM_STATE_TRANSMIT` and `ENUM_STATE_RESET`.
  - `CLOG2`.
  - Default timing constants (RESET, T0H, T1H cycles at 7 MHz).
- Natural sub-module: anton_neopixel_reset_timer, containing the counter, terminal-count detect and clear/freeze logic. It has parameter RESET_CYCLES and outputs a terminal pulse.

## Test plan
- Pattern check: pixel_data=24'h800001, one pixel, limit reached.
  - Bit 0 (a '1'): line high 5 cycles then low 3.
  - Bits 1–22 ('0's): each high 2, low 6.
  - Bit 23 (a '1'): high 5, low 3.
  - Then state=RESET.
- Loop reset: reg_ctrl_loop=1.
  - After the frame, the line stays low exactly 350 cycles with stream_reset high.
  - frame_done pulses once.
  - State returns to TRANSMIT one cycle later.
- One-shot: reg_ctrl_loop=0. After 350 reset cycles, run_clear and frame_done pulse once, and state stays RESET.
- Run drop: deassert reg_ctrl_run at sub-bit 3 of bit 5.
  - Line goes low next cycle, and the timer and state are frozen.
  - After re-assert, output resumes at sub-bit 3.
- Init mid-frame: assert reg_ctrl_init during TRANSMIT. The next cycle shows state=RESET, line 0 and timer 0.
- Reset: assert syncn_reset=0 mid-frame. All outputs take their reset values on the next clock edge; asynchronous toggling between edges has no effect.
